// File: rtl/uart_cfg_pkg.sv
// Shared types, baud table and divisor math for the UART configuration bank.
// Used by uart_cfg_bank (optional readback via UART_CFG_READBACK_EN) and uart_cfg_chan.
package uart_cfg_pkg;

  typedef struct packed {
    logic [3:0] baud_sel;
    logic [1:0] data_size;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } cfg_t;

  typedef enum logic [1:0] {
    UNCFG   = 2'd0,
    PENDING = 2'd1,
    ACTIVE  = 2'd2
  } chan_state_e;

  localparam int MAX_BAUD_SEL = 8;

  localparam int unsigned BAUD_TABLE [0:MAX_BAUD_SEL] = '{
    32'd9600, 32'd19200, 32'd38400, 32'd57600, 32'd115200,
    32'd230400, 32'd460800, 32'd921600, 32'd1843200
  };

  // Rounded 16x oversampling divisor, clamped to [1, 2^div_w - 1].
  function automatic logic [63:0] baud_div_calc(input longint unsigned clk_hz,
                                                input longint unsigned baud,
                                                input int unsigned     div_w);
    longint unsigned q;
    longint unsigned max_v;
    q     = (clk_hz + 8 * baud) / (16 * baud);
    max_v = (64'd1 << div_w) - 64'd1;
    if (q > max_v) q = max_v;
    if (q == 0) q = 1;
    return q;
  endfunction

endpackage

// File: rtl/uart_cfg_chan.sv
// One channel of the config bank: UNCFG/PENDING/ACTIVE FSM with staged and
// committed registers; commits only while the channel's TX/RX report idle.
module uart_cfg_chan
  import uart_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int          DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  cfg_t             wr_cfg,
  input  logic             idle,
  output logic             cfg_valid,
  output logic             cfg_pending,
  output logic             cfg_update,
  output cfg_t             cfg_out,
  output logic [DIV_W-1:0] baud_div
);

  localparam logic [63:0]      RESET_DIV_FULL = baud_div_calc(CLK_FREQ_HZ, BAUD_TABLE[0], DIV_W);
  localparam logic [DIV_W-1:0] RESET_DIV      = RESET_DIV_FULL[DIV_W-1:0];

  logic [DIV_W-1:0] div_lut [16];

  for (genvar b = 0; b < 16; b++) begin : g_div
    if (b <= MAX_BAUD_SEL) begin : g_used
      localparam logic [63:0] D = baud_div_calc(CLK_FREQ_HZ, BAUD_TABLE[b], DIV_W);
      assign div_lut[b] = D[DIV_W-1:0];
    end else begin : g_unused
      assign div_lut[b] = RESET_DIV;
    end
  end

  chan_state_e      state_q, state_d;
  cfg_t             staged_q, staged_d;
  cfg_t             committed_q, committed_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             valid_q, valid_d;
  logic             pending_q, pending_d;
  logic             update_q, update_d;
  logic             commit;

  // A commit always takes the value staged before this cycle; a simultaneous
  // write lands in staging and keeps the channel pending.
  always_comb begin
    commit      = (state_q == PENDING) && idle;
    state_d     = state_q;
    staged_d    = wr_en ? wr_cfg : staged_q;
    committed_d = commit ? staged_q : committed_q;
    div_d       = commit ? div_lut[staged_q.baud_sel] : div_q;
    case (state_q)
      UNCFG:   if (wr_en) state_d = PENDING;
      PENDING: if (!wr_en && idle) state_d = ACTIVE;
      ACTIVE:  if (wr_en) state_d = PENDING;
      default: state_d = UNCFG;
    endcase
    valid_d   = valid_q | commit;
    pending_d = (state_d == PENDING);
    update_d  = commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNCFG;
      staged_q    <= '0;
      committed_q <= '0;
      div_q       <= RESET_DIV;
      valid_q     <= 1'b0;
      pending_q   <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      staged_q    <= staged_d;
      committed_q <= committed_d;
      div_q       <= div_d;
      valid_q     <= valid_d;
      pending_q   <= pending_d;
      update_q    <= update_d;
    end
  end

  assign cfg_valid   = valid_q;
  assign cfg_pending = pending_q;
  assign cfg_update  = update_q;
  assign cfg_out     = committed_q;
  assign baud_div    = div_q;

endmodule

// File: rtl/uart_cfg_bank.sv
// Multi-channel UART config bank: write decode/validation plus per-channel staging.
// Define UART_CFG_READBACK_EN to add the registered rd_chan/rd_cfg readback port.
module uart_cfg_bank
  import uart_cfg_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int          DIV_W       = 16,
  parameter int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  input  logic [CH_W-1:0]              wr_chan,
  input  logic [3:0]                   wr_baud_sel,
  input  logic [1:0]                   wr_data_size,
  input  logic                         wr_parity_en,
  input  logic                         wr_parity_odd,
  input  logic                         wr_stop2,
  output logic                         wr_ack,
  output logic                         wr_err,
  input  logic [NUM_CH-1:0]            chan_idle,
  output logic [NUM_CH-1:0]            cfg_valid,
  output logic [NUM_CH-1:0]            cfg_pending,
  output logic [NUM_CH-1:0]            cfg_update,
  output cfg_t [NUM_CH-1:0]            cfg_out,
  output logic [NUM_CH-1:0][DIV_W-1:0] baud_div
`ifdef UART_CFG_READBACK_EN
  ,
  input  logic [CH_W-1:0]              rd_chan,
  output cfg_t                         rd_cfg
`endif
);

  logic              chan_ok;
  logic              baud_ok;
  logic              accept;
  logic              reject;
  cfg_t              wr_cfg;
  logic [NUM_CH-1:0] wr_en;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;

  // Widen the channel compare so a power-of-two NUM_CH does not overflow.
  always_comb begin
    chan_ok  = ({1'b0, wr_chan} < (CH_W + 1)'(NUM_CH));
    baud_ok  = (wr_baud_sel <= 4'(MAX_BAUD_SEL));
    accept   = wr_valid && chan_ok && baud_ok;
    reject   = wr_valid && !(chan_ok && baud_ok);
    wr_ack_d = accept;
    wr_err_d = reject;
    wr_cfg   = '{baud_sel:   wr_baud_sel,
                 data_size:  wr_data_size,
                 parity_en:  wr_parity_en,
                 parity_odd: wr_parity_odd,
                 stop2:      wr_stop2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_ack = wr_ack_q;
  assign wr_err = wr_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign wr_en[i] = accept && (wr_chan == CH_W'(i));

    uart_cfg_chan #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .DIV_W       (DIV_W)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en[i]),
      .wr_cfg      (wr_cfg),
      .idle        (chan_idle[i]),
      .cfg_valid   (cfg_valid[i]),
      .cfg_pending (cfg_pending[i]),
      .cfg_update  (cfg_update[i]),
      .cfg_out     (cfg_out[i]),
      .baud_div    (baud_div[i])
    );
  end

`ifdef UART_CFG_READBACK_EN
  cfg_t rd_cfg_q, rd_cfg_d;

  always_comb begin
    rd_cfg_d = '0;
    if ({1'b0, rd_chan} < (CH_W + 1)'(NUM_CH)) rd_cfg_d = cfg_out[rd_chan];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_cfg_q <= '0;
    else        rd_cfg_q <= rd_cfg_d;
  end

  assign rd_cfg = rd_cfg_q;
`endif

endmodule

// File: tb/tb_uart_cfg_bank.sv
// Self-checking bench for uart_cfg_bank: scoreboard of expected commits plus a
// small bench-side model of committed state per channel.
module tb_uart_cfg_bank;
  import uart_cfg_pkg::*;

  localparam int NCH   = 5;
  localparam int CHW   = 3;
  localparam int DIVW  = 16;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       wr_valid = 1'b0;
  logic [CHW-1:0]             wr_chan = '0;
  logic [3:0]                 wr_baud_sel = '0;
  logic [1:0]                 wr_data_size = '0;
  logic                       wr_parity_en = 1'b0;
  logic                       wr_parity_odd = 1'b0;
  logic                       wr_stop2 = 1'b0;
  logic                       wr_ack;
  logic                       wr_err;
  logic [NCH-1:0]             chan_idle = '1;
  logic [NCH-1:0]             cfg_valid;
  logic [NCH-1:0]             cfg_pending;
  logic [NCH-1:0]             cfg_update;
  cfg_t [NCH-1:0]             cfg_out;
  logic [NCH-1:0][DIVW-1:0]   baud_div;
`ifdef UART_CFG_READBACK_EN
  logic [CHW-1:0]             rd_chan = '0;
  cfg_t                       rd_cfg;
`endif

  uart_cfg_bank #(
    .NUM_CH      (NCH),
    .CLK_FREQ_HZ (50_000_000),
    .DIV_W       (DIVW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_chan       (wr_chan),
    .wr_baud_sel   (wr_baud_sel),
    .wr_data_size  (wr_data_size),
    .wr_parity_en  (wr_parity_en),
    .wr_parity_odd (wr_parity_odd),
    .wr_stop2      (wr_stop2),
    .wr_ack        (wr_ack),
    .wr_err        (wr_err),
    .chan_idle     (chan_idle),
    .cfg_valid     (cfg_valid),
    .cfg_pending   (cfg_pending),
    .cfg_update    (cfg_update),
    .cfg_out       (cfg_out),
    .baud_div      (baud_div)
`ifdef UART_CFG_READBACK_EN
    ,
    .rd_chan       (rd_chan),
    .rd_cfg        (rd_cfg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int              chan;
    cfg_t            cfg;
    logic [DIVW-1:0] div;
  } exp_t;

  exp_t            sb[$];
  cfg_t            exp_cfg   [NCH];
  logic [DIVW-1:0] exp_div   [NCH];
  logic [NCH-1:0]  exp_valid;
  int              checks   = 0;
  int              failures = 0;

  localparam logic [DIVW-1:0] DIV9600 = 16'd326;

  function automatic logic [DIVW-1:0] ref_div(input int sel);
    int bauds [9] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600, 1843200};
    int b;
    b = bauds[sel];
    return DIVW'((50_000_000 + b * 8) / (b * 16));
  endfunction

  function automatic cfg_t mk_cfg(input int baud, input int ds, input bit pe,
                                  input bit po, input bit s2);
    cfg_t c;
    c.baud_sel   = 4'(baud);
    c.data_size  = 2'(ds);
    c.parity_en  = pe;
    c.parity_odd = po;
    c.stop2      = s2;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input int ch, input cfg_t c);
    wr_valid      = 1'b1;
    wr_chan       = CHW'(ch);
    wr_baud_sel   = c.baud_sel;
    wr_data_size  = c.data_size;
    wr_parity_en  = c.parity_en;
    wr_parity_odd = c.parity_odd;
    wr_stop2      = c.stop2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      exp_cfg[i] = '0;
      exp_div[i] = DIV9600;
    end
    exp_valid = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++; if (cfg_valid !== '0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", cfg_valid); end
    checks++; if (cfg_pending !== '0) begin failures++; $display("[TB] FAIL reset_pending got=%b exp=0", cfg_pending); end
    checks++; if ({wr_ack, wr_err, cfg_update} !== '0) begin failures++; $display("[TB] FAIL reset_pulses ack=%b err=%b upd=%b exp=0", wr_ack, wr_err, cfg_update); end
    for (int i = 0; i < NCH; i++) begin
      checks++; if (cfg_out[i] !== '0) begin failures++; $display("[TB] FAIL reset_cfg_out[%0d] got=%h exp=0", i, cfg_out[i]); end
      checks++; if (baud_div[i] !== ref_div(0) || baud_div[i] !== DIV9600) begin failures++; $display("[TB] FAIL reset_baud_div[%0d] got=%0d exp=%0d", i, baud_div[i], DIV9600); end
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_commit();
    exp_t e;
    cfg_t c;
    chan_idle = '1;
    c = mk_cfg(4, 3, 1'b1, 1'b1, 1'b0);
    drive_write(2, c);
    sb.push_back('{chan: 2, cfg: c, div: ref_div(4)});
    tick();
    checks++; if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin failures++; $display("[TB] FAIL wc_ack ack=%b err=%b exp ack=1 err=0", wr_ack, wr_err); end
    checks++; if (cfg_pending[2] !== 1'b1 || cfg_update !== '0) begin failures++; $display("[TB] FAIL wc_pending pend=%b upd=%b exp pend[2]=1 upd=0", cfg_pending, cfg_update); end
    checks++; if (cfg_out[2] !== '0) begin failures++; $display("[TB] FAIL wc_staged_hidden got=%h exp=0", cfg_out[2]); end
    wr_valid = 1'b0;
    tick();
    checks++; if (cfg_update !== 5'b00100) begin failures++; $display("[TB] FAIL wc_update got=%b exp=00100", cfg_update); end
    e = sb.pop_front();
    checks++; if (cfg_out[e.chan] !== e.cfg) begin failures++; $display("[TB] FAIL wc_cfg_out got=%h exp=%h", cfg_out[e.chan], e.cfg); end
    checks++; if (baud_div[e.chan] !== e.div || baud_div[2] !== 16'd27) begin failures++; $display("[TB] FAIL wc_baud_div got=%0d exp=27", baud_div[2]); end
    checks++; if (cfg_valid !== 5'b00100 || cfg_pending !== '0 || wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL wc_flags valid=%b pend=%b ack=%b exp valid=00100 pend=0 ack=0", cfg_valid, cfg_pending, wr_ack); end
    exp_cfg[e.chan] = e.cfg; exp_div[e.chan] = e.div; exp_valid[e.chan] = 1'b1;
    tick();
    checks++; if (cfg_update !== '0) begin failures++; $display("[TB] FAIL wc_update_pulse got=%b exp=0", cfg_update); end
  endtask

  task automatic test_idle_hold();
    exp_t e;
    cfg_t c;
    chan_idle = 5'b11101;
    c = mk_cfg(2, 1, 1'b1, 1'b0, 1'b1);
    drive_write(1, c);
    sb.push_back('{chan: 1, cfg: c, div: ref_div(2)});
    tick();
    wr_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (cfg_pending[1] !== 1'b1 || cfg_update[1] !== 1'b0 || cfg_out[1] !== exp_cfg[1] || baud_div[1] !== exp_div[1]) begin
        failures++;
        $display("[TB] FAIL hold_cycle%0d pend=%b upd=%b cfg=%h div=%0d exp pend=1 upd=0 cfg=%h div=%0d",
                 k, cfg_pending[1], cfg_update[1], cfg_out[1], baud_div[1], exp_cfg[1], exp_div[1]);
      end
      tick();
    end
    chan_idle[1] = 1'b1;
    tick();
    checks++; if (cfg_update !== 5'b00010) begin failures++; $display("[TB] FAIL hold_update got=%b exp=00010", cfg_update); end
    e = sb.pop_front();
    checks++; if (cfg_out[e.chan] !== e.cfg || baud_div[e.chan] !== e.div) begin failures++; $display("[TB] FAIL hold_commit cfg=%h div=%0d exp cfg=%h div=%0d", cfg_out[e.chan], baud_div[e.chan], e.cfg, e.div); end
    exp_cfg[e.chan] = e.cfg; exp_div[e.chan] = e.div; exp_valid[e.chan] = 1'b1;
    tick();
  endtask

  task automatic test_last_write_wins();
    exp_t e;
    cfg_t c;
    int   pulses = 0;
    chan_idle[0] = 1'b0;
    drive_write(0, mk_cfg(1, 0, 1'b0, 1'b0, 1'b0));
    tick();
    checks++; if (wr_ack !== 1'b1) begin failures++; $display("[TB] FAIL lww_ack1 got=%b exp=1", wr_ack); end
    c = mk_cfg(7, 2, 1'b0, 1'b1, 1'b1);
    drive_write(0, c);
    sb.push_back('{chan: 0, cfg: c, div: ref_div(7)});
    tick();
    wr_valid = 1'b0;
    checks++; if (wr_ack !== 1'b1 || cfg_pending[0] !== 1'b1) begin failures++; $display("[TB] FAIL lww_ack2 ack=%b pend=%b exp 1 1", wr_ack, cfg_pending[0]); end
    chan_idle[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (cfg_update[0] === 1'b1) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++; if (cfg_out[0] !== e.cfg || baud_div[0] !== e.div) begin failures++; $display("[TB] FAIL lww_commit cfg=%h div=%0d exp cfg=%h div=%0d", cfg_out[0], baud_div[0], e.cfg, e.div); end
          exp_cfg[0] = e.cfg; exp_div[0] = e.div; exp_valid[0] = 1'b1;
        end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL lww_pulses got=%0d exp=1", pulses); end
    checks++; if (cfg_out[0].baud_sel !== 4'd7) begin failures++; $display("[TB] FAIL lww_final_baud got=%0d exp=7", cfg_out[0].baud_sel); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    cfg_t a, b;
    chan_idle[4] = 1'b0;
    a = mk_cfg(5, 3, 1'b0, 1'b0, 1'b0);
    b = mk_cfg(8, 1, 1'b1, 1'b1, 1'b0);
    drive_write(4, a);
    sb.push_back('{chan: 4, cfg: a, div: ref_div(5)});
    tick();
    chan_idle[4] = 1'b1;
    drive_write(4, b);
    sb.push_back('{chan: 4, cfg: b, div: ref_div(8)});
    tick();
    wr_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (cfg_update !== 5'b10000 || cfg_out[4] !== e.cfg || baud_div[4] !== e.div) begin failures++; $display("[TB] FAIL b2b_first upd=%b cfg=%h div=%0d exp upd=10000 cfg=%h div=%0d", cfg_update, cfg_out[4], baud_div[4], e.cfg, e.div); end
    checks++; if (cfg_pending[4] !== 1'b1 || wr_ack !== 1'b1) begin failures++; $display("[TB] FAIL b2b_still_pending pend=%b ack=%b exp 1 1", cfg_pending[4], wr_ack); end
    tick();
    e = sb.pop_front();
    checks++; if (cfg_update !== 5'b10000 || cfg_out[4] !== e.cfg || baud_div[4] !== e.div) begin failures++; $display("[TB] FAIL b2b_second upd=%b cfg=%h div=%0d exp upd=10000 cfg=%h div=%0d", cfg_update, cfg_out[4], baud_div[4], e.cfg, e.div); end
    checks++; if (cfg_pending[4] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_pend_clear got=%b exp=0", cfg_pending[4]); end
    exp_cfg[4] = e.cfg; exp_div[4] = e.div; exp_valid[4] = 1'b1;
    tick();
  endtask

  task automatic test_reject();
    int   bad_ch   [3] = '{0, 5, 7};
    int   bad_baud [3] = '{9, 3, 15};
    chan_idle = '1;
    for (int t = 0; t < 3; t++) begin
      drive_write(bad_ch[t], mk_cfg(bad_baud[t], 2, 1'b1, 1'b0, 1'b1));
      tick();
      wr_valid = 1'b0;
      checks++; if (wr_err !== 1'b1 || wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL rej%0d_pulse err=%b ack=%b exp err=1 ack=0", t, wr_err, wr_ack); end
      checks++; if (cfg_pending !== '0) begin failures++; $display("[TB] FAIL rej%0d_pending got=%b exp=0", t, cfg_pending); end
      tick();
      checks++; if (wr_err !== 1'b0 || cfg_update !== '0 || cfg_valid !== exp_valid) begin failures++; $display("[TB] FAIL rej%0d_after err=%b upd=%b valid=%b exp err=0 upd=0 valid=%b", t, wr_err, cfg_update, cfg_valid, exp_valid); end
      for (int i = 0; i < NCH; i++) begin
        checks++; if (cfg_out[i] !== exp_cfg[i] || baud_div[i] !== exp_div[i]) begin failures++; $display("[TB] FAIL rej%0d_state[%0d] cfg=%h div=%0d exp cfg=%h div=%0d", t, i, cfg_out[i], baud_div[i], exp_cfg[i], exp_div[i]); end
      end
    end
  endtask

`ifdef UART_CFG_READBACK_EN
  task automatic test_readback();
    rd_chan = 3'd4;
    tick();
    checks++; if (rd_cfg !== exp_cfg[4]) begin failures++; $display("[TB] FAIL rb_ch4 got=%h exp=%h", rd_cfg, exp_cfg[4]); end
    rd_chan = 3'd6;
    tick();
    checks++; if (rd_cfg !== '0) begin failures++; $display("[TB] FAIL rb_oob got=%h exp=0", rd_cfg); end
  endtask
`endif

  task automatic test_async_reset();
    chan_idle[3] = 1'b0;
    drive_write(3, mk_cfg(6, 3, 1'b1, 1'b1, 1'b1));
    tick();
    wr_valid = 1'b0;
    checks++; if (cfg_pending[3] !== 1'b1 || wr_ack !== 1'b1) begin failures++; $display("[TB] FAIL ar_pre pend=%b ack=%b exp 1 1", cfg_pending[3], wr_ack); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (cfg_valid !== '0 || cfg_pending !== '0 || cfg_update !== '0 || wr_ack !== 1'b0 || wr_err !== 1'b0) begin failures++; $display("[TB] FAIL ar_async valid=%b pend=%b upd=%b ack=%b err=%b exp all 0", cfg_valid, cfg_pending, cfg_update, wr_ack, wr_err); end
    for (int i = 0; i < NCH; i++) begin
      checks++; if (cfg_out[i] !== '0 || baud_div[i] !== DIV9600) begin failures++; $display("[TB] FAIL ar_out[%0d] cfg=%h div=%0d exp cfg=0 div=326", i, cfg_out[i], baud_div[i]); end
    end
    tick();
    rst_n = 1'b1;
    chan_idle = '1;
    repeat (3) begin
      tick();
      checks++; if (cfg_update !== '0 || cfg_pending !== '0 || cfg_valid !== '0) begin failures++; $display("[TB] FAIL ar_post upd=%b pend=%b valid=%b exp all 0", cfg_update, cfg_pending, cfg_valid); end
    end
    checks++; if (cfg_out[3] !== '0 || baud_div[3] !== DIV9600) begin failures++; $display("[TB] FAIL ar_ch3 cfg=%h div=%0d exp cfg=0 div=326", cfg_out[3], baud_div[3]); end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_idle_hold();
    test_last_write_wins();
    test_back_to_back();
    test_reject();
`ifdef UART_CFG_READBACK_EN
    test_readback();
`endif
    test_async_reset();
    checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
